// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// line geometry and helpers that derive index/tag widths from the cache parameters.
package icache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int word_size, input int num_lines);
        return word_size - OFFSET_W - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Data, tag and valid storage for icache_direct: one combinational read port,
// one word-write port, one tag/valid-write port, single-line invalidate and clear-all.
module icache_array
    import icache_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_LINES = 8,
    parameter int INDEX_W   = 3,
    parameter int TAG_W     = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_all_i,
    input  logic [INDEX_W-1:0]   rd_index_i,
    input  logic [OFFSET_W-1:0]  rd_offset_i,
    output logic [WORD_SIZE-1:0] rd_data_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic                 rd_valid_o,
    input  logic                 wr_en_i,
    input  logic [INDEX_W-1:0]   wr_index_i,
    input  logic [OFFSET_W-1:0]  wr_offset_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    input  logic                 tv_en_i,
    input  logic [INDEX_W-1:0]   tv_index_i,
    input  logic [TAG_W-1:0]     tv_tag_i,
    input  logic                 tv_valid_i,
    input  logic                 inv_en_i,
    input  logic [INDEX_W-1:0]   inv_index_i
);

    logic [WORD_SIZE-1:0] data_q [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;

    assign rd_data_o  = data_q[{rd_index_i, rd_offset_i}];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];

    // Data and tags carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
        end
        if (tv_en_i) begin
            tag_q[tv_index_i] <= tv_tag_i;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (inv_en_i) begin
            valid_d[inv_index_i] = 1'b0;
        end
        if (tv_en_i) begin
            valid_d[tv_index_i] = tv_valid_i;
        end
        if (clear_all_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with 4-word line refill over a valid/ack
// memory handshake. Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_direct
    import icache_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_LINES = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 i_readM,
    input  logic                 i_writeM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    output logic                 m_readM,
    output logic [WORD_SIZE-1:0] m_address,
    input  logic [WORD_SIZE-1:0] m_data,
    input  logic                 m_ack
`ifdef ICACHE_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
`endif
);

    localparam int INDEX_W = index_width(NUM_LINES);
    localparam int TAG_W   = tag_width(WORD_SIZE, NUM_LINES);

    logic [OFFSET_W-1:0]  req_offset;
    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;

    logic [WORD_SIZE-1:0] rd_data;
    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_valid;
    logic                 lookup_hit;
    logic                 idle;

    logic [1:0]           state_q,      state_d;
    logic [TAG_W-1:0]     miss_tag_q,   miss_tag_d;
    logic [INDEX_W-1:0]   miss_index_q, miss_index_d;
    logic [OFFSET_W-1:0]  word_q,       word_d;
    logic                 poison_q,     poison_d;
    logic [WORD_SIZE-1:0] data_q;

    logic                 wr_en;
    logic                 tv_en;
    logic                 tv_valid;
    logic                 inv_en;

    assign req_offset = i_address[OFFSET_W-1:0];
    assign req_index  = i_address[OFFSET_W +: INDEX_W];
    assign req_tag    = i_address[WORD_SIZE-1 -: TAG_W];

    assign lookup_hit = rd_valid && (rd_tag == req_tag);
    assign idle       = (state_q == ST_IDLE);

    // Hits are served straight from the array; otherwise i_data holds its last value.
    assign i_ready   = idle && i_readM && lookup_hit;
    assign i_data    = i_ready ? rd_data : data_q;
    assign m_readM   = (state_q == ST_REQ);
    assign m_address = {miss_tag_q, miss_index_q, word_q};

    always_comb begin
        state_d      = state_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        word_d       = word_q;
        poison_d     = poison_q;
        wr_en        = 1'b0;
        tv_en        = 1'b0;
        tv_valid     = 1'b0;
        inv_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                poison_d = 1'b0;
                if (i_readM && !lookup_hit) begin
                    state_d      = ST_REQ;
                    miss_tag_d   = req_tag;
                    miss_index_d = req_index;
                    word_d       = '0;
                end else if (i_writeM && !i_readM && lookup_hit) begin
                    inv_en = 1'b1;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    poison_d = 1'b1;
                end
                if (m_ack) begin
                    wr_en  = 1'b1;
                    word_d = word_q + 1'b1;
                    if (word_q == 2'd3) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                // A flush seen anywhere in this refill leaves the line invalid.
                tv_en    = 1'b1;
                tv_valid = !(poison_q || flush);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= ST_IDLE;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            word_q       <= '0;
            poison_q     <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            word_q       <= word_d;
            poison_q     <= poison_d;
            data_q       <= i_data;
        end
    end

    icache_array #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk_i       (clk),
        .rst_i       (reset_n),
        .clear_all_i (flush),
        .rd_index_i  (req_index),
        .rd_offset_i (req_offset),
        .rd_data_o   (rd_data),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid),
        .wr_en_i     (wr_en),
        .wr_index_i  (miss_index_q),
        .wr_offset_i (word_q),
        .wr_data_i   (m_data),
        .tv_en_i     (tv_en),
        .tv_index_i  (miss_index_q),
        .tv_tag_i    (miss_tag_q),
        .tv_valid_i  (tv_valid),
        .inv_en_i    (inv_en),
        .inv_index_i (req_index)
    );

`ifdef ICACHE_STATS_EN
    logic [WORD_SIZE-1:0] hit_q,  hit_d;
    logic [WORD_SIZE-1:0] miss_q, miss_d;

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (i_readM && i_ready && (hit_q != {WORD_SIZE{1'b1}})) begin
            hit_d = hit_q + 1'b1;
        end
        if (idle && i_readM && !lookup_hit && (miss_q != {WORD_SIZE{1'b1}})) begin
            miss_d = miss_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct against a line-level cache model and a
// memory responder returning 0xA000 + address with a configurable ack period.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        i_readM;
    logic        i_writeM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        m_readM;
    logic [15:0] m_address;
    logic [15:0] m_data = 16'h0000;
    logic        m_ack  = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    int          ack_period = 1;
    int          ack_cnt    = 0;
    logic [15:0] fetched[$];
    bit          stable_err = 1'b0;
    bit          prev_pending = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    // Model: which tag each of the 8 lines currently holds.
    bit          mv[8];
    int          mt[8];

    always #5 clk = ~clk;

    icache_direct dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .i_readM    (i_readM),
        .i_writeM   (i_writeM),
        .i_address  (i_address),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .m_readM    (m_readM),
        .m_address  (m_address),
        .m_data     (m_data),
        .m_ack      (m_ack)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Memory: acks every ack_period-th requesting cycle and logs the addresses served.
    always @(negedge clk) begin
        if (m_readM === 1'b1 && reset_n === 1'b0) begin
            if (prev_pending && m_address !== prev_addr) stable_err = 1'b1;
            ack_cnt++;
            if (ack_cnt >= ack_period) begin
                m_ack = 1'b1;
                m_data = 16'hA000 + m_address;
                fetched.push_back(m_address);
                ack_cnt = 0;
                prev_pending = 1'b0;
            end else begin
                m_ack = 1'b0;
                prev_pending = 1'b1;
                prev_addr = m_address;
            end
        end else begin
            m_ack = 1'b0;
            ack_cnt = 0;
            prev_pending = 1'b0;
        end
    end

    function automatic int line_of(input logic [15:0] a);
        return (int'(a) / 4) % 8;
    endfunction

    function automatic int tag_of(input logic [15:0] a);
        return int'(a) / 32;
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return mv[line_of(a)] && (mt[line_of(a)] == tag_of(a));
    endfunction

    task automatic model_fill(input logic [15:0] a);
        mv[line_of(a)] = 1'b1;
        mt[line_of(a)] = tag_of(a);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input int budget, output int cyc,
                           output logic [15:0] d, output bit ok, output logic mrd);
        @(posedge clk); #1;
        fetched.delete();
        i_readM = 1'b1;
        i_writeM = 1'b0;
        i_address = a;
        cyc = 0;
        ok = 1'b0;
        d = 16'hxxxx;
        mrd = 1'bx;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (i_ready === 1'b1) begin
                ok = 1'b1;
                d = i_data;
                mrd = m_readM;
            end
        end
        @(posedge clk); #1;
        i_readM = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        flush = 1'b0;
        i_readM = 1'b1;
        i_writeM = 1'b0;
        i_address = 16'h0012;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b expected 0", i_ready); end
        checks++; if (i_data !== 16'h0000) begin errors++; $display("FAIL reset_i_data: got %h expected 0000", i_data); end
        checks++; if (m_readM !== 1'b0) begin errors++; $display("FAIL reset_m_readM: got %b expected 0", m_readM); end
        checks++; if (m_address !== 16'h0000) begin errors++; $display("FAIL reset_m_address: got %h expected 0000", m_address); end
        i_readM = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss();
        int cyc; logic [15:0] d; bit ok; logic mrd;
        do_read(16'h0012, 20, cyc, d, ok, mrd);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cold_ready: got no i_ready expected within 20 cycles"); end
        checks++; if (cyc != 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", cyc); end
        checks++; if (d !== 16'hA012) begin errors++; $display("FAIL cold_data: got %h expected A012", d); end
        checks++; if (fetched.size() != 4) begin errors++; $display("FAIL cold_fetch_count: got %0d expected 4", fetched.size()); end
        if (fetched.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fetched[i] !== 16'h0010 + 16'(i)) begin
                    errors++; $display("FAIL cold_m_address%0d: got %h expected %h", i, fetched[i], 16'h0010 + 16'(i));
                end
            end
        end
        model_fill(16'h0012);
    endtask

    task automatic test_hit();
        int cyc; logic [15:0] d; bit ok; logic mrd;
        logic [15:0] addrs[2];
        addrs[0] = 16'h0013;
        addrs[1] = 16'h0010;
        for (int k = 0; k < 2; k++) begin
            do_read(addrs[k], 20, cyc, d, ok, mrd);
            checks++; if (cyc != 1) begin errors++; $display("FAIL hit_latency_%h: got %0d expected 1", addrs[k], cyc); end
            checks++; if (d !== 16'hA000 + addrs[k]) begin errors++; $display("FAIL hit_data_%h: got %h expected %h", addrs[k], d, 16'hA000 + addrs[k]); end
            checks++; if (mrd !== 1'b0) begin errors++; $display("FAIL hit_m_readM_%h: got %b expected 0", addrs[k], mrd); end
            checks++; if (fetched.size() != 0) begin errors++; $display("FAIL hit_fetch_%h: got %0d expected 0", addrs[k], fetched.size()); end
        end
    endtask

    task automatic test_conflict();
        int cyc; logic [15:0] d; bit ok; logic mrd;
        do_read(16'h0032, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 7) begin errors++; $display("FAIL conflict_latency: got %0d expected 7", cyc); end
        checks++; if (d !== 16'hA032) begin errors++; $display("FAIL conflict_data: got %h expected A032", d); end
        checks++; if (fetched.size() != 4) begin errors++; $display("FAIL conflict_fetch_count: got %0d expected 4", fetched.size()); end
        if (fetched.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fetched[i] !== 16'h0030 + 16'(i)) begin
                    errors++; $display("FAIL conflict_m_address%0d: got %h expected %h", i, fetched[i], 16'h0030 + 16'(i));
                end
            end
        end
        model_fill(16'h0032);
        do_read(16'h0012, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 7) begin errors++; $display("FAIL conflict_reread_latency: got %0d expected 7", cyc); end
        checks++; if (d !== 16'hA012) begin errors++; $display("FAIL conflict_reread_data: got %h expected A012", d); end
        model_fill(16'h0012);
    endtask

    task automatic test_slow_addr_change();
        int cyc; bit ok; logic [15:0] d; logic [15:0] exp;
        ack_period = 3;
        stable_err = 1'b0;
        @(posedge clk); #1;
        fetched.delete();
        i_readM = 1'b1;
        i_address = 16'h0040;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        i_address = 16'h0080;
        cyc = 0; ok = 1'b0; d = 16'hxxxx;
        while (cyc < 80 && !ok) begin
            @(negedge clk);
            cyc++;
            if (i_ready === 1'b1) begin ok = 1'b1; d = i_data; end
        end
        @(posedge clk); #1;
        i_readM = 1'b0;
        ack_period = 1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL slow_ready: got no i_ready expected within 80 cycles"); end
        checks++; if (d !== 16'hA080) begin errors++; $display("FAIL slow_data: got %h expected A080", d); end
        checks++; if (stable_err !== 1'b0) begin errors++; $display("FAIL slow_addr_stable: got change before ack expected stable"); end
        checks++; if (fetched.size() != 8) begin errors++; $display("FAIL slow_fetch_count: got %0d expected 8", fetched.size()); end
        if (fetched.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                exp = (i < 4) ? 16'h0040 + 16'(i) : 16'h0080 + 16'(i - 4);
                checks++;
                if (fetched[i] !== exp) begin
                    errors++; $display("FAIL slow_m_address%0d: got %h expected %h", i, fetched[i], exp);
                end
            end
        end
        model_fill(16'h0040);
        model_fill(16'h0080);
    endtask

    task automatic test_flush_refill();
        int cyc; logic [15:0] d; bit ok; logic mrd;
        @(posedge clk); #1;
        fetched.delete();
        i_readM = 1'b1;
        i_address = 16'h0055;
        @(posedge clk); #1;
        flush = 1'b1;
        i_readM = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        model_clear();
        checks++; if (fetched.size() != 4) begin errors++; $display("FAIL flushref_fetch_count: got %0d expected 4", fetched.size()); end
        checks++; if (m_readM !== 1'b0) begin errors++; $display("FAIL flushref_idle: got m_readM=%b expected 0", m_readM); end
        do_read(16'h0055, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 7) begin errors++; $display("FAIL flushref_reread_latency: got %0d expected 7", cyc); end
        checks++; if (d !== 16'hA055) begin errors++; $display("FAIL flushref_reread_data: got %h expected A055", d); end
        model_fill(16'h0055);
        do_read(16'h0012, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 7) begin errors++; $display("FAIL flushref_other_line: got %0d expected 7", cyc); end
        model_fill(16'h0012);
    endtask

    task automatic test_flush_idle();
        int cyc; logic [15:0] d; bit ok; logic mrd;
        @(posedge clk); #1;
        i_readM = 1'b1;
        i_address = 16'h0055;
        flush = 1'b1;
        @(negedge clk);
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL flushidle_hit_ready: got %b expected 1", i_ready); end
        checks++; if (i_data !== 16'hA055) begin errors++; $display("FAIL flushidle_hit_data: got %h expected A055", i_data); end
        @(posedge clk); #1;
        flush = 1'b0;
        i_readM = 1'b0;
        model_clear();
        do_read(16'h0055, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 7) begin errors++; $display("FAIL flushidle_reread_latency: got %0d expected 7", cyc); end
        model_fill(16'h0055);
    endtask

    task automatic test_write_invalidate();
        int cyc; logic [15:0] d; bit ok; logic mrd;
        @(posedge clk); #1;
        i_writeM = 1'b1; i_address = 16'h0075;
        @(posedge clk); #1;
        i_writeM = 1'b0;
        do_read(16'h0055, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 1) begin errors++; $display("FAIL winv_other_tag: got latency %0d expected 1", cyc); end
        @(posedge clk); #1;
        i_readM = 1'b1; i_writeM = 1'b1; i_address = 16'h0055;
        @(negedge clk);
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL winv_rw_ready: got %b expected 1", i_ready); end
        @(posedge clk); #1;
        i_readM = 1'b0; i_writeM = 1'b0;
        do_read(16'h0055, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 1) begin errors++; $display("FAIL winv_rw_keeps_line: got latency %0d expected 1", cyc); end
        @(posedge clk); #1;
        i_writeM = 1'b1; i_address = 16'h0057;
        @(posedge clk); #1;
        i_writeM = 1'b0;
        do_read(16'h0055, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 7) begin errors++; $display("FAIL winv_match: got latency %0d expected 7", cyc); end
        checks++; if (d !== 16'hA055) begin errors++; $display("FAIL winv_refill_data: got %h expected A055", d); end
        model_fill(16'h0055);
    endtask

    task automatic test_random();
        int cyc; logic [15:0] d; bit ok; logic mrd;
        int r; logic [15:0] a; bit exp_hit;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            a = 16'($urandom_range(0, 127));
            if (r < 7) begin
                exp_hit = model_hit(a);
                do_read(a, 20, cyc, d, ok, mrd);
                checks++; if (cyc != (exp_hit ? 1 : 7)) begin errors++; $display("FAIL rand_latency_%h: got %0d expected %0d", a, cyc, exp_hit ? 1 : 7); end
                checks++; if (d !== 16'hA000 + a) begin errors++; $display("FAIL rand_data_%h: got %h expected %h", a, d, 16'hA000 + a); end
                checks++; if (fetched.size() != (exp_hit ? 0 : 4)) begin errors++; $display("FAIL rand_fetch_%h: got %0d expected %0d", a, fetched.size(), exp_hit ? 0 : 4); end
                model_fill(a);
            end else if (r < 9) begin
                @(posedge clk); #1;
                i_writeM = 1'b1; i_address = a;
                @(posedge clk); #1;
                i_writeM = 1'b0;
                if (model_hit(a)) mv[line_of(a)] = 1'b0;
            end else begin
                @(posedge clk); #1;
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                model_clear();
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        int cyc; logic [15:0] d; bit ok; logic mrd;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        do_read(16'h0020, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 7) begin errors++; $display("FAIL rstmid_prefill: got latency %0d expected 7", cyc); end
        @(posedge clk); #1;
        i_readM = 1'b1; i_address = 16'h0064;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (m_readM !== 1'b1) begin errors++; $display("FAIL rstmid_in_req: got m_readM=%b expected 1", m_readM); end
        reset_n = 1'b1;
        #1;
        checks++; if (m_readM !== 1'b0) begin errors++; $display("FAIL rstmid_m_readM: got %b expected 0", m_readM); end
        checks++; if (m_address !== 16'h0000) begin errors++; $display("FAIL rstmid_m_address: got %h expected 0000", m_address); end
        i_readM = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        model_clear();
`ifdef ICACHE_STATS_EN
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rstmid_hit_count: got %0d expected 0", hit_count); end
        checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL rstmid_miss_count: got %0d expected 0", miss_count); end
`endif
        do_read(16'h0020, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 7) begin errors++; $display("FAIL rstmid_refilled_miss: got latency %0d expected 7", cyc); end
        checks++; if (d !== 16'hA020) begin errors++; $display("FAIL rstmid_data: got %h expected A020", d); end
        model_fill(16'h0020);
        do_read(16'h0021, 20, cyc, d, ok, mrd);
        checks++; if (cyc != 1) begin errors++; $display("FAIL rstmid_rehit: got latency %0d expected 1", cyc); end
`ifdef ICACHE_STATS_EN
        checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL stats_hit_count: got %0d expected 2", hit_count); end
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL stats_miss_count: got %0d expected 1", miss_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_slow_addr_change();
        test_flush_refill();
        test_flush_idle();
        test_write_invalidate();
        test_random();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
